// File: rtl/ascon_input_loader_if.sv
// Bus bundle between the host word stream, the input loader and the ASCON core.
// Signal names are given from the loader's point of view.
interface ascon_input_loader_if;
   logic         i_s_valid;
   logic [31:0]  i_s_data;
   logic         o_s_ready;
   logic [127:0] o_key;
   logic [127:0] o_nonce;
   logic         o_start;
   logic [63:0]  o_data;
   logic         o_data_valid;
   logic         i_data_taken;
   logic         i_done;

   // Host/core side: drives words and core feedback, observes loader outputs.
   modport master (
      output i_s_valid, i_s_data, i_data_taken, i_done,
      input  o_s_ready, o_key, o_nonce, o_start, o_data, o_data_valid
   );

   // Loader side.
   modport slave (
      input  i_s_valid, i_s_data, i_data_taken, i_done,
      output o_s_ready, o_key, o_nonce, o_start, o_data, o_data_valid
   );
endinterface

// File: rtl/ascon_input_loader.sv
// ASCON-128 input loader: captures key and nonce from a 32-bit host stream,
// pulses the core start, then feeds one associated-data block followed by
// NB_PT_BLOCKS plaintext blocks, each held until the core reports it taken.
module ascon_input_loader #(
   parameter int NB_PT_BLOCKS = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_sys_enable,
   input  logic i_start,
   output logic o_busy,
   ascon_input_loader_if.slave bus
);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_LOAD_KEY   = 4'd1;
   localparam logic [3:0] S_LOAD_NONCE = 4'd2;
   localparam logic [3:0] S_START      = 4'd3;
   localparam logic [3:0] S_FILL_HI    = 4'd4;
   localparam logic [3:0] S_FILL_LO    = 4'd5;
   localparam logic [3:0] S_PRESENT    = 4'd6;
   localparam logic [3:0] S_WAIT_DONE  = 4'd7;

   // One associated-data block plus the plaintext blocks; 4 bits so that
   // NB_PT_BLOCKS = 7 (total 8) does not wrap.
   localparam logic [3:0] BLOCKS_TOTAL = 4'(1 + NB_PT_BLOCKS);

   logic [3:0]   state_q,  state_d;
   logic [1:0]   wcnt_q,   wcnt_d;
   logic [2:0]   bcnt_q,   bcnt_d;
   logic [127:0] key_q,    key_d;
   logic [127:0] nonce_q,  nonce_d;
   logic [63:0]  data_q,   data_d;
   logic         dvalid_q, dvalid_d;

   logic         ready;
   logic         xfer;
   logic [3:0]   bcnt_inc;

   // Place host word n of a 128-bit field; word 0 is the most significant.
   function automatic logic [127:0] put_word(input logic [127:0] v,
                                             input logic [1:0]   n,
                                             input logic [31:0]  w);
      logic [127:0] r;
      r = v;
      case (n)
         2'd0:    r[127:96] = w;
         2'd1:    r[95:64]  = w;
         2'd2:    r[63:32]  = w;
         default: r[31:0]   = w;
      endcase
      return r;
   endfunction

   assign ready    = (state_q == S_LOAD_KEY) || (state_q == S_LOAD_NONCE) ||
                     (state_q == S_FILL_HI)  || (state_q == S_FILL_LO);
   assign xfer     = bus.i_s_valid && ready;
   assign bcnt_inc = {1'b0, bcnt_q} + 4'd1;

   assign bus.o_s_ready    = ready;
   assign bus.o_key        = key_q;
   assign bus.o_nonce      = nonce_q;
   assign bus.o_start      = (state_q == S_START);
   assign bus.o_data       = data_q;
   assign bus.o_data_valid = dvalid_q;
   assign o_busy           = (state_q != S_IDLE);

   // Next-state logic: sequencing, word/block counters and field capture.
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      bcnt_d   = bcnt_q;
      key_d    = key_q;
      nonce_d  = nonce_q;
      data_d   = data_q;
      dvalid_d = dvalid_q;

      if (!i_sys_enable) begin
         state_d  = S_IDLE;
         wcnt_d   = 2'd0;
         bcnt_d   = 3'd0;
         key_d    = '0;
         nonce_d  = '0;
         data_d   = '0;
         dvalid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  state_d = S_LOAD_KEY;
                  wcnt_d  = 2'd0;
               end
            end
            S_LOAD_KEY: begin
               if (xfer) begin
                  key_d  = put_word(key_q, wcnt_q, bus.i_s_data);
                  wcnt_d = wcnt_q + 2'd1;
                  if (wcnt_q == 2'd3) begin
                     state_d = S_LOAD_NONCE;
                     wcnt_d  = 2'd0;
                  end
               end
            end
            S_LOAD_NONCE: begin
               if (xfer) begin
                  nonce_d = put_word(nonce_q, wcnt_q, bus.i_s_data);
                  wcnt_d  = wcnt_q + 2'd1;
                  if (wcnt_q == 2'd3) begin
                     state_d = S_START;
                  end
               end
            end
            S_START: begin
               bcnt_d  = 3'd0;
               state_d = S_FILL_HI;
            end
            S_FILL_HI: begin
               if (xfer) begin
                  data_d[63:32] = bus.i_s_data;
                  state_d       = S_FILL_LO;
               end
            end
            S_FILL_LO: begin
               if (xfer) begin
                  data_d[31:0] = bus.i_s_data;
                  dvalid_d     = 1'b1;
                  state_d      = S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (bus.i_data_taken) begin
                  dvalid_d = 1'b0;
                  bcnt_d   = bcnt_inc[2:0];
                  state_d  = (bcnt_inc < BLOCKS_TOTAL) ? S_FILL_HI : S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (bus.i_done) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers; every output register clears on reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         wcnt_q   <= 2'd0;
         bcnt_q   <= 3'd0;
         key_q    <= '0;
         nonce_q  <= '0;
         data_q   <= '0;
         dvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         bcnt_q   <= bcnt_d;
         key_q    <= key_d;
         nonce_q  <= nonce_d;
         data_q   <= data_d;
         dvalid_q <= dvalid_d;
      end
   end

endmodule

// File: tb/tb_ascon_input_loader.sv
// Testbench for ascon_input_loader: two instances (4 and 1 plaintext blocks)
// share the host stream; only the selected one is started per message.
module tb_ascon_input_loader;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        sys_en = 1'b0;
   logic        start_host = 1'b0;
   logic        start_core = 1'b0;
   logic        sel = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        taken_core = 1'b0;
   logic        taken_spur = 1'b0;
   logic        done_core = 1'b0;
   logic        done_host = 1'b0;
   logic        busy4, busy1;

   ascon_input_loader_if bus4 ();
   ascon_input_loader_if bus1 ();

   assign bus4.i_s_valid    = s_valid;
   assign bus4.i_s_data     = s_data;
   assign bus4.i_data_taken = taken_core | taken_spur;
   assign bus4.i_done       = done_core | done_host;
   assign bus1.i_s_valid    = s_valid;
   assign bus1.i_s_data     = s_data;
   assign bus1.i_data_taken = taken_core | taken_spur;
   assign bus1.i_done       = done_core | done_host;

   ascon_input_loader #(.NB_PT_BLOCKS(4)) u_dut4 (
      .clock(clock), .reset_n(reset_n), .i_sys_enable(sys_en),
      .i_start((start_host | start_core) & ~sel), .o_busy(busy4), .bus(bus4.slave));

   ascon_input_loader #(.NB_PT_BLOCKS(1)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .i_sys_enable(sys_en),
      .i_start((start_host | start_core) & sel), .o_busy(busy1), .bus(bus1.slave));

   // View of the currently selected instance
   logic         ready, cur_start, dvalid, busy;
   logic [127:0] key, nonce;
   logic [63:0]  data;
   assign ready     = sel ? bus1.o_s_ready    : bus4.o_s_ready;
   assign cur_start = sel ? bus1.o_start      : bus4.o_start;
   assign dvalid    = sel ? bus1.o_data_valid : bus4.o_data_valid;
   assign busy      = sel ? busy1             : busy4;
   assign key       = sel ? bus1.o_key        : bus4.o_key;
   assign nonce     = sel ? bus1.o_nonce      : bus4.o_nonce;
   assign data      = sel ? bus1.o_data       : bus4.o_data;

   always #5 clock = ~clock;

   int start_cnt = 0;
   always @(posedge clock) if (cur_start) start_cnt <= start_cnt + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: the message as host words, and what must come out.
   logic [31:0]  words[$];
   logic [127:0] exp_key, exp_nonce;
   logic [63:0]  exp_blk[$];

   task automatic build_msg(input int nblk, input bit fixed);
      words.delete();
      exp_blk.delete();
      for (int i = 0; i < 8 + 2 * nblk; i++) begin
         if (fixed && i < 8) begin
            logic [7:0] b;
            b = 8'(4 * i) + ((i >= 4) ? 8'h00 : 8'h00);
            if (i >= 4) b = 8'h10 + 8'(4 * (i - 4));
            words.push_back({b, b + 8'd1, b + 8'd2, b + 8'd3});
         end else begin
            words.push_back($urandom);
         end
      end
      exp_key   = {words[0], words[1], words[2], words[3]};
      exp_nonce = {words[4], words[5], words[6], words[7]};
      for (int b = 0; b < nblk; b++) exp_blk.push_back({words[8 + 2 * b], words[9 + 2 * b]});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},  ready,     0);
      chk({tag, "_key"},    key,       0);
      chk({tag, "_nonce"},  nonce,     0);
      chk({tag, "_start"},  cur_start, 0);
      chk({tag, "_data"},   data,      0);
      chk({tag, "_dvalid"}, dvalid,    0);
      chk({tag, "_busy"},   busy,      0);
   endtask

   // Offer one word; spur=1 pulses i_done, spur=2 pulses i_data_taken on the transfer edge.
   task automatic put_word(input logic [31:0] w, input int spur, input bit bp);
      int g;
      g = 0;
      if (bp) begin
         s_valid = 1'b0;
         @(posedge clock); #1;
      end
      s_valid = 1'b1;
      s_data  = w;
      while (!ready && g < 300) begin
         @(posedge clock); #1;
         g++;
      end
      if (!ready) chk("ready_timeout", 0, 1);
      if (spur == 1) done_host = 1'b1;
      if (spur == 2) taken_spur = 1'b1;
      @(posedge clock); #1;
      s_valid    = 1'b0;
      done_host  = 1'b0;
      taken_spur = 1'b0;
   endtask

   // mode 0: full message, 1: reset during FILL_LO of block 3, 2: enable drop there.
   task automatic run_host(input int nblk, input int mode, input bit bp);
      int nw;
      for (int i = 0; i < 8; i++) put_word(words[i], (i == 5) ? 1 : 0, bp);
      chk("start_latency", cur_start, 1);
      chk("key", key, exp_key);
      chk("nonce", nonce, exp_nonce);
      nw = (mode == 0) ? 2 * nblk : 7;
      for (int j = 0; j < nw; j++) put_word(words[8 + j], (j == 2) ? 2 : 0, bp);
      if (mode == 1) begin
         chk("abort_in_fill_lo", ready, 1);
         #2 reset_n = 1'b0;
         #1 chk_all_zero("rst_abort");
         @(posedge clock); #1;
         reset_n = 1'b1;
      end else if (mode == 2) begin
         chk("abort_in_fill_lo", ready, 1);
         sys_en = 1'b0;
         @(posedge clock); #1;
         chk_all_zero("en_abort");
         sys_en = 1'b1;
      end
   endtask

   task automatic run_core(input int nblk, input int mode, input int stall_blk);
      int serve, g, d;
      serve = (mode == 0) ? nblk : 3;
      for (int b = 0; b < serve; b++) begin
         g = 0;
         while (!dvalid && g < 500) begin
            @(posedge clock); #1;
            g++;
         end
         chk($sformatf("blk%0d_valid", b), dvalid, 1);
         chk($sformatf("blk%0d_data", b), data, exp_blk[b]);
         d = (b == stall_blk) ? 20 : int'($urandom_range(0, 3));
         for (int k = 0; k < d; k++) begin
            @(posedge clock); #1;
            chk($sformatf("blk%0d_hold_valid", b), dvalid, 1);
            chk($sformatf("blk%0d_hold_data", b), data, exp_blk[b]);
            chk($sformatf("blk%0d_hold_ready", b), ready, 0);
         end
         taken_core = 1'b1;
         @(posedge clock); #1;
         taken_core = 1'b0;
         chk($sformatf("blk%0d_valid_fall", b), dvalid, 0);
      end
      if (mode == 0) begin
         repeat (2) begin @(posedge clock); #1; end
         chk("wait_done_busy", busy, 1);
         chk("wait_done_ready", ready, 0);
         chk("wait_done_no_valid", dvalid, 0);
         start_core = 1'b1;
         @(posedge clock); #1;
         start_core = 1'b0;
         chk("start_ignored_ready", ready, 0);
         chk("start_ignored_busy", busy, 1);
         done_core = 1'b1;
         @(posedge clock); #1;
         done_core = 1'b0;
         chk("done_busy_low", busy, 0);
         @(posedge clock); #1;
         chk("idle_busy_low", busy, 0);
         chk("idle_ready_low", ready, 0);
      end
   endtask

   task automatic run_msg(input bit nsel, input int mode, input bit bp, input int stall, input bit fixed);
      int nblk, s0;
      sel  = nsel;
      nblk = nsel ? 2 : 5;
      build_msg(nblk, fixed);
      s0 = start_cnt;
      start_host = 1'b1;
      @(posedge clock); #1;
      start_host = 1'b0;
      chk("busy_after_start", busy, 1);
      fork
         run_host(nblk, mode, bp);
         run_core(nblk, mode, stall);
      join
      if (mode == 0) chk("start_pulses", start_cnt - s0, 1);
   endtask

   initial begin
      sys_en  = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk_all_zero("reset");
      reset_n = 1'b1;
      @(posedge clock); #1;

      run_msg(1'b0, 0, 1'b0, 2, 1'b1);   // nominal, stall on block 2
      run_msg(1'b0, 0, 1'b1, -1, 1'b1);  // host backpressure
      run_msg(1'b0, 1, 1'b0, -1, 1'b0);  // reset abort
      run_msg(1'b0, 0, 1'b0, -1, 1'b0);
      run_msg(1'b0, 2, 1'b1, -1, 1'b0);  // enable abort
      run_msg(1'b0, 0, 1'b0, -1, 1'b0);
      run_msg(1'b1, 0, 1'b0, -1, 1'b0);  // one plaintext block
      run_msg(1'b1, 0, 1'b1, 1, 1'b0);
      for (int m = 0; m < 4; m++)
         run_msg(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
